// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state type, default strip timing and colour helpers shared by the WS2812 transmitter.
// Latency: none (declarations and pure functions only).
// Backpressure: none. WS2812_GAMMA_EN adds the gamma-2.2 lookup table used between buffer and shifter.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } ws_state_e;

  // Defaults for a 78-LED strip driven from a 148.5 MHz pixel clock.
  localparam int WS_NUM_LED  = 78;
  localparam int WS_T_BIT    = 186;   // 1.25 us bit slot
  localparam int WS_T0H      = 59;    // 0.40 us high for a 0 bit
  localparam int WS_T1H      = 119;   // 0.80 us high for a 1 bit
  localparam int WS_T_RESET  = 11880; // 80 us low latch gap

  // The strip expects green first, then red, then blue, each MSB first.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

`ifdef WS2812_GAMMA_EN
  // Table is built at elaboration time; out = floor(255 * (in/255)^2.2).
  function automatic logic [2047:0] gamma_table();
    logic [2047:0] t;
    real           v;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      v = 255.0 * ((i / 255.0) ** 2.2);
      t[i*8 +: 8] = 8'($rtoi(v));
    end
    return t;
  endfunction

  localparam logic [2047:0] GAMMA_TBL = gamma_table();

  function automatic logic [7:0] gamma_lut(input logic [7:0] x);
    return GAMMA_TBL[{x, 3'b000} +: 8];
  endfunction
`endif

endpackage

// File: rtl/ws2812_line_buf.sv
// ws2812_line_buf: two banks of NUM_LED x 24-bit colour storage, one write port and one registered read port.
// Latency: read data appears one clkn falling edge after the address is presented.
// Backpressure: none; a write and a read may occur every cycle (different banks in normal use).
module ws2812_line_buf #(
  parameter int NUM_LED = 78,
  parameter int IW      = 7
) (
  input  logic          clkn,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [IW-1:0] wr_idx,
  input  logic [23:0]   wr_dat,
  input  logic          rd_bank,
  input  logic [IW-1:0] rd_idx,
  output logic [23:0]   rd_dat
);

  logic [23:0] mem_q [2][NUM_LED];
  logic [23:0] rd_dat_q;

  // Storage array with a synchronous write and a registered read; no reset so it maps onto block RAM.
  always_ff @(negedge clkn) begin
    if (wr_en) begin
      mem_q[wr_bank][wr_idx] <= wr_dat;
    end
    rd_dat_q <= mem_q[rd_bank][rd_idx];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ws2812_strip_tx.sv
// ws2812_strip_tx: captures a per-frame colour burst into a ping-pong buffer and serialises it as a WS2812 GRB bitstream.
// Latency: first led_dout rise 2 clkn edges after the last entry is written (3 with WS2812_GAMMA_EN defined).
// Backpressure: none; dv_in is always accepted, and a completed but unsent bank is overwritten with an overrun pulse.
module ws2812_strip_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_LED = WS_NUM_LED,
  parameter int T_BIT   = WS_T_BIT,
  parameter int T0H     = WS_T0H,
  parameter int T1H     = WS_T1H,
  parameter int T_RESET = WS_T_RESET
) (
  input  logic        clkn,
  input  logic        reset,
  input  logic        vs,
  input  logic        dv_in,
  input  logic [23:0] rgb_in,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int IW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam int SW = $clog2(T_BIT);
  localparam int LW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LED - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(T_BIT - 1);
  localparam logic [SW-1:0] HI0       = SW'(T0H);
  localparam logic [SW-1:0] HI1       = SW'(T1H);
  localparam logic [LW-1:0] LAT_LAST  = LW'(T_RESET - 1);

`ifdef WS2812_GAMMA_EN
  // LOAD waits one extra cycle for the gamma register.
  localparam logic LOAD_LAST = 1'b1;
`else
  localparam logic LOAD_LAST = 1'b0;
`endif

  ws_state_e     state_q, state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          tx_bank_q, tx_bank_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] led_idx_q, led_idx_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          load_cnt_q, load_cnt_d;
  logic [23:0]   sh_q, sh_d;
  logic          led_dout_q, led_dout_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;

  logic          swap;
  logic          wr_en;
  logic          rd_bank;
  logic [IW-1:0] rd_idx;
  logic [23:0]   rd_dat;
  logic [23:0]   src_dat;

  ws2812_line_buf #(
    .NUM_LED (NUM_LED),
    .IW      (IW)
  ) u_line_buf (
    .clkn    (clkn),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_d),
    .wr_idx  (wr_ptr_q),
    .wr_dat  (rgb_in),
    .rd_bank (rd_bank),
    .rd_idx  (rd_idx),
    .rd_dat  (rd_dat)
  );

`ifdef WS2812_GAMMA_EN
  logic [23:0] gam_q, gam_d;

  // Per-channel gamma correction of the buffer read data.
  always_comb begin
    gam_d = {gamma_lut(rd_dat[23:16]), gamma_lut(rd_dat[15:8]), gamma_lut(rd_dat[7:0])};
  end

  // Gamma pipeline register between the RAM read and the shift-register load.
  always_ff @(negedge clkn or posedge reset) begin
    if (reset) begin
      gam_q <= '0;
    end else begin
      gam_q <= gam_d;
    end
  end

  assign src_dat = gam_q;
`else
  assign src_dat = rd_dat;
`endif

  // Next-state logic: transmit FSM, bit timing counters and the write-side bookkeeping.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    tx_bank_d    = tx_bank_q;
    pending_d    = pending_q;
    led_idx_d    = led_idx_q;
    bit_cnt_d    = bit_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    load_cnt_d   = load_cnt_q;
    sh_d         = sh_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    swap         = 1'b0;
    wr_en        = 1'b0;
    rd_bank      = tx_bank_q;
    rd_idx       = led_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        // Read LED 0 of the bank about to become the transmit bank, so LOAD finds it ready.
        rd_bank = wr_bank_q;
        rd_idx  = '0;
        if (pending_q && (wr_ptr_q == '0)) begin
          swap       = 1'b1;
          wr_bank_d  = tx_bank_q;
          tx_bank_d  = wr_bank_q;
          pending_d  = 1'b0;
          led_idx_d  = '0;
          load_cnt_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          sh_d       = rgb_to_grb(src_dat);
          bit_cnt_d  = 5'd0;
          slot_cnt_d = '0;
          state_d    = ST_SHIFT;
        end else begin
          load_cnt_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        // The next LED is read for the whole current LED, so the reload at the end of bit 23 is seamless
        // and the gamma stage (when present) has long settled.
        rd_idx = (led_idx_q == LAST_IDX) ? led_idx_q : led_idx_q + IW'(1);
        if (slot_cnt_q == SLOT_LAST) begin
          slot_cnt_d = '0;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = 5'd0;
            if (led_idx_q != LAST_IDX) begin
              led_idx_d = led_idx_q + IW'(1);
              sh_d      = rgb_to_grb(src_dat);
            end else begin
              lat_cnt_d = '0;
              state_d   = ST_LATCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sh_d      = {sh_q[22:0], 1'b0};
          end
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end

      ST_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Write side. A write in the swap cycle goes to the bank that just became the write bank (wr_bank_d).
    // A partial frame cut by vs has already overwritten part of the pending bank, so that bank is dropped too.
    if (vs && (wr_ptr_q != '0)) begin
      wr_ptr_d  = '0;
      pending_d = 1'b0;
    end else if (dv_in) begin
      wr_en = 1'b1;
      if (wr_ptr_q == LAST_IDX) begin
        wr_ptr_d  = '0;
        pending_d = 1'b1;
        overrun_d = pending_q && !swap;
      end else begin
        wr_ptr_d = wr_ptr_q + IW'(1);
      end
    end

    // Output is registered from the next-cycle counters so it lines up exactly with the slot boundaries.
    led_dout_d = (state_d == ST_SHIFT) && (slot_cnt_d < (sh_d[23] ? HI1 : HI0));
  end

  // FSM state register.
  always_ff @(negedge clkn or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and bookkeeping registers; reset drives every output low at once.
  always_ff @(negedge clkn or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      wr_bank_q    <= 1'b0;
      tx_bank_q    <= 1'b1;
      pending_q    <= 1'b0;
      led_idx_q    <= '0;
      bit_cnt_q    <= 5'd0;
      slot_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      load_cnt_q   <= 1'b0;
      sh_q         <= '0;
      led_dout_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_bank_q    <= wr_bank_d;
      tx_bank_q    <= tx_bank_d;
      pending_q    <= pending_d;
      led_idx_q    <= led_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      load_cnt_q   <= load_cnt_d;
      sh_q         <= sh_d;
      led_dout_q   <= led_dout_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign led_dout   = led_dout_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ws2812_strip_tx.sv
module tb_ws2812_strip_tx;

  localparam int NL = 4;
  localparam int TB = 12;
  localparam int T0 = 4;
  localparam int T1 = 8;
  localparam int TR = 30;
`ifdef WS2812_GAMMA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clkn = 1'b0;
  logic        reset = 1'b1;
  logic        vs = 1'b0;
  logic        dv_in = 1'b0;
  logic [23:0] rgb_in = 24'h0;
  logic        led_dout, busy, frame_done, overrun;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int busy_cnt = 0;
  int hi_cnt = 0;

  ws2812_strip_tx #(
    .NUM_LED (NL),
    .T_BIT   (TB),
    .T0H     (T0),
    .T1H     (T1),
    .T_RESET (TR)
  ) dut (
    .clkn       (clkn),
    .reset      (reset),
    .vs         (vs),
    .dv_in      (dv_in),
    .rgb_in     (rgb_in),
    .led_dout   (led_dout),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clkn = ~clkn;

  // Count of active (falling) edges so far.
  always @(negedge clkn) cyc <= cyc + 1;

  // Event counters sampled half a cycle after the active edge.
  always @(posedge clkn) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (led_dout === 1'b1) hi_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Expected byte after optional gamma; only 00, 80 and FF bytes are used by the vectors.
  function automatic logic [95:0] xform(input logic [95:0] g);
    logic [95:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      b = g[8*i +: 8];
`ifdef WS2812_GAMMA_EN
      if (b == 8'h80) b = 8'h37;
`endif
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  // Writes NL entries back to back; l returns the edge index of the last write.
  task automatic burst(input logic [95:0] d, output int l);
    for (int i = 0; i < NL; i++) begin
      dv_in  = 1'b1;
      rgb_in = d[95-24*i -: 24];
      @(posedge clkn);
    end
    dv_in  = 1'b0;
    rgb_in = 24'h0;
    l = cyc;
  endtask

  // Follows one frame whose transmission is triggered at edge l0 + LAT, decoding and timing every slot.
  task automatic capture(input string nm, input int l0, input logic [95:0] exp);
    int k, hi, glitch, busy_lo, lat_bad;
    logic [95:0] got;
    k = 0;
    while (led_dout !== 1'b1 && k < 16) begin
      @(posedge clkn);
      k++;
    end
    check({nm, "_first_rise"}, cyc - l0, LAT);
    if (led_dout !== 1'b1) return;
    glitch = 0;
    busy_lo = 0;
    got = '0;
    for (int b = 0; b < 24*NL; b++) begin
      hi = 0;
      for (int s = 0; s < TB; s++) begin
        if (busy !== 1'b1) busy_lo++;
        if (led_dout === 1'b1) begin
          if (hi != s) glitch++;
          hi++;
        end
        @(posedge clkn);
      end
      if (hi == T1) got[95-b] = 1'b1;
      else if (hi != T0) glitch++;
    end
    for (int i = 0; i < NL; i++)
      check($sformatf("%s_led%0d_grb", nm, i), got[95-24*i -: 24], exp[95-24*i -: 24]);
    check({nm, "_slot_timing_errs"}, glitch, 0);
    check({nm, "_busy_low_in_shift"}, busy_lo, 0);
    lat_bad = 0;
    for (int s = 0; s < TR; s++) begin
      if (led_dout !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) lat_bad++;
      @(posedge clkn);
    end
    check({nm, "_latch_gap_errs"}, lat_bad, 0);
    check({nm, "_done_busy_dout_at_end"}, {frame_done, busy, led_dout}, 3'b100);
    @(posedge clkn);
    check({nm, "_done_pulse_width"}, frame_done, 0);
  endtask

  typedef struct {
    logic [95:0] rgb;
    logic [95:0] grb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int l, k, ov0, b0, h0;

    vecs[0] = '{rgb: {24'h000000, 24'h000000, 24'h000000, 24'h000000},
                grb: {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
    vecs[1] = '{rgb: {24'hFF0000, 24'h000000, 24'h000000, 24'h000000},
                grb: {24'h00FF00, 24'h000000, 24'h000000, 24'h000000}};
    vecs[2] = '{rgb: {24'h00FF00, 24'h0000FF, 24'h80FF00, 24'hFFFFFF},
                grb: {24'hFF0000, 24'h0000FF, 24'hFF8000, 24'hFFFFFF}};
    vecs[3] = '{rgb: {24'h80FF80, 24'h008000, 24'hFF00FF, 24'h800000},
                grb: {24'hFF8080, 24'h800000, 24'h00FFFF, 24'h008000}};
    vecs[4] = '{rgb: {24'h808080, 24'h000000, 24'h000000, 24'h000000},
                grb: {24'h808080, 24'h000000, 24'h000000, 24'h000000}};

    // Reset state
    repeat (3) @(posedge clkn);
    check("rst_led_dout", led_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (3) @(posedge clkn);

    // Table-driven frames
    ov0 = ovr_cnt;
    for (int v = 0; v < 5; v++) begin
      burst(vecs[v].rgb, l);
      capture($sformatf("vec%0d", v), l, xform(vecs[v].grb));
    end
    check("table_no_overrun", ovr_cnt - ov0, 0);

    // Second burst during transmission, third before the swap: one overrun, third burst sent next
    ov0 = ovr_cnt;
    burst({24'h111111, 24'h222222, 24'h333333, 24'h444444}, l);
    repeat (20) @(posedge clkn);
    burst({24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF}, l);
    repeat (5) @(posedge clkn);
    burst({24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}, l);
    k = 0;
    while (frame_done !== 1'b1 && k < 3000) begin
      @(posedge clkn);
      k++;
    end
    check("ovr_frame1_done_seen", frame_done, 1);
    capture("ovr_frame2", cyc, xform({24'h0000FF, 24'hFF0000, 24'h00FF00, 24'hFFFFFF}));
    check("ovr_pulse_count", ovr_cnt - ov0, 1);

    // vs discards a partial burst
    for (int i = 0; i < 2; i++) begin
      dv_in = 1'b1;
      rgb_in = 24'hFFFFFF;
      @(posedge clkn);
    end
    dv_in = 1'b0;
    vs = 1'b1;
    @(posedge clkn);
    vs = 1'b0;
    b0 = busy_cnt;
    h0 = hi_cnt;
    repeat (100) @(posedge clkn);
    check("vs_no_busy", busy_cnt - b0, 0);
    check("vs_no_dout", hi_cnt - h0, 0);
    burst({24'h00FF00, 24'h000000, 24'h0000FF, 24'h800000}, l);
    capture("vs_next", l, xform({24'hFF0000, 24'h000000, 24'h0000FF, 24'h008000}));

    // Reset mid-SHIFT
    burst({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, l);
    k = 0;
    while (led_dout !== 1'b1 && k < 16) begin
      @(posedge clkn);
      k++;
    end
    repeat (TB * 5) @(posedge clkn);
    check("prerst_dout_high", led_dout, 1);
    #2 reset = 1'b1;
    #1 check("async_rst_outputs", {led_dout, busy, frame_done, overrun}, 4'b0000);
    @(posedge clkn);
    reset = 1'b0;
    b0 = busy_cnt;
    h0 = hi_cnt;
    repeat (150) @(posedge clkn);
    check("postrst_no_busy", busy_cnt - b0, 0);
    check("postrst_no_dout", hi_cnt - h0, 0);
    burst({24'h000000, 24'hFF0000, 24'h000000, 24'h00FF00}, l);
    capture("postrst", l, xform({24'h000000, 24'h00FF00, 24'h000000, 24'hFF0000}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
